oldest2_issue_queue: RTL

Age-ordered, dual-issue instruction buffer feeding the RCU issue stage. It holds up to DEPTH entries in a circular buffer and tracks the oldest-entry pointer, waiting and ready state. Each cycle it issues the two oldest ready entries through an embedded oldest-2 arbiter with bypass; newly enqueued ready entries may issue in the same cycle without being written. It is the requester side of the oldest-2 arbitration interface: it produces the request vector, priority pointer and new-request bits, and consumes the grants.

---
 rtl/oldest2_issue_queue_pkg.sv | 38 +++
 rtl/oldest2_abitter_bps.sv | 70 +++++++
 rtl/oldest2_issue_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/oldest2_issue_queue_pkg.sv
// Shared RCU definitions for the oldest-2 issue queue: sizes, entry layout and
// the head-advance helper used after issue clears.
package oldest2_issue_queue_pkg;

  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
  } entry_t;

  // First valid slot in [head, tail), or tail when that span holds only holes.
  function automatic logic [PTR_W:0] next_head(
    input logic [DEPTH-1:0] valid,
    input logic [PTR_W:0]   head,
    input logic [PTR_W:0]   tail
  );
    logic [PTR_W:0] span;
    logic [PTR_W:0] ptr;
    logic [PTR_W:0] res;
    logic           found;
    span  = tail - head;
    res   = tail;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ptr = head + (PTR_W+1)'(i);
      if (!found && ((PTR_W+1)'(i) < span) && valid[ptr[PTR_W-1:0]]) begin
        res   = ptr;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/oldest2_abitter_bps.sv
// Oldest-2 arbiter: queued requests scanned circularly from the priority pointer,
// then new (bypass) request 0, then 1. Purely combinational, no backpressure.
module oldest2_abitter_bps #(
  parameter int SEL_WIDTH      = 8,
  parameter int PRIORITY_WIDTH = 3
) (
  input  logic [SEL_WIDTH-1:0]      req,
  input  logic [PRIORITY_WIDTH-1:0] prio,
  input  logic [1:0]                new_req,
  output logic [SEL_WIDTH-1:0]      grant,
  output logic [1:0]                grant_new,
  output logic                      first_valid,
  output logic [PRIORITY_WIDTH-1:0] first_idx,
  output logic                      new_grant_first,
  output logic                      first_sel,
  output logic                      second_valid,
  output logic [PRIORITY_WIDTH-1:0] second_idx,
  output logic                      new_grant_second,
  output logic                      second_sel
);

  logic [1:0]                hits;
  logic [PRIORITY_WIDTH-1:0] idx;

  always_comb begin
    grant            = '0;
    grant_new        = '0;
    first_valid      = 1'b0;
    first_idx        = '0;
    new_grant_first  = 1'b0;
    first_sel        = 1'b0;
    second_valid     = 1'b0;
    second_idx       = '0;
    new_grant_second = 1'b0;
    second_sel       = 1'b0;
    hits             = 2'd0;
    idx              = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      idx = prio + PRIORITY_WIDTH'(k);
      if (req[idx] && hits != 2'd2) begin
        grant[idx] = 1'b1;
        if (hits == 2'd0) begin
          first_valid = 1'b1;
          first_idx   = idx;
        end else begin
          second_valid = 1'b1;
          second_idx   = idx;
        end
        hits = hits + 2'd1;
      end
    end
    // sel records which new port won, so the top can route its payload
    for (int n = 0; n < 2; n++) begin
      if (new_req[n] && hits != 2'd2) begin
        grant_new[n] = 1'b1;
        if (hits == 2'd0) begin
          first_valid     = 1'b1;
          new_grant_first = 1'b1;
          first_sel       = 1'(n);
        end else begin
          second_valid     = 1'b1;
          new_grant_second = 1'b1;
          second_sel       = 1'(n);
        end
        hits = hits + 2'd1;
      end
    end
  end

endmodule

// File: rtl/oldest2_issue_queue.sv
// Age-ordered dual-issue queue; each cycle issues the two oldest ready entries, queued or bypassed.
// Latency: bypass 0, queued >=1 cycle; enq_ready_o needs 2 free slots, issue_stall_i withholds all grants.
module oldest2_issue_queue #(
  parameter int DEPTH  = oldest2_issue_queue_pkg::DEPTH,
  parameter int PTR_W  = oldest2_issue_queue_pkg::PTR_W,
  parameter int DATA_W = oldest2_issue_queue_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              enq0_valid_i,
  input  logic              enq1_valid_i,
  input  logic              enq0_rdy_i,
  input  logic              enq1_rdy_i,
  input  logic [DATA_W-1:0] enq0_data_i,
  input  logic [DATA_W-1:0] enq1_data_i,
  output logic              enq_ready_o,
  input  logic [DEPTH-1:0]  wake_mask_i,
  input  logic              issue_stall_i,
  output logic              iss0_valid_o,
  output logic              iss1_valid_o,
  output logic [DATA_W-1:0] iss0_data_o,
  output logic [DATA_W-1:0] iss1_data_o,
  output logic              iss0_bypass_o,
  output logic              iss1_bypass_o,
  output logic [PTR_W:0]    count_o
);

  import oldest2_issue_queue_pkg::*;

  entry_t           ent_q [DEPTH];
  entry_t           ent_n [DEPTH];
  logic [PTR_W:0]   head_q, tail_q, head_n, tail_n, wr_ptr, span;
  logic [DEPTH-1:0] req, grant, valid_n;
  logic [1:0]       grant_new;
  logic             mask, acc0, acc1, wr0, wr1;
  logic             g0_valid, g0_new, g0_sel, g1_valid, g1_new, g1_sel;
  logic [PTR_W-1:0] g0_idx, g1_idx;

  assign span        = tail_q - head_q;
  assign count_o     = span;
  assign enq_ready_o = (span <= (PTR_W+1)'(DEPTH-2));

  // Reset is folded in so issue valids fall with rstn even while enqueue inputs are live.
  assign mask = issue_stall_i | flush_i | ~rstn;

  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) req[i] = ent_q[i].valid & ent_q[i].ready & ~mask;
  end

  oldest2_abitter_bps #(
    .SEL_WIDTH      (DEPTH),
    .PRIORITY_WIDTH (PTR_W)
  ) u_arb (
    .req              (req),
    .prio             (head_q[PTR_W-1:0]),
    .new_req          ({enq1_valid_i & enq1_rdy_i & enq_ready_o & ~mask,
                        enq0_valid_i & enq0_rdy_i & enq_ready_o & ~mask}),
    .grant            (grant),
    .grant_new        (grant_new),
    .first_valid      (g0_valid),
    .first_idx        (g0_idx),
    .new_grant_first  (g0_new),
    .first_sel        (g0_sel),
    .second_valid     (g1_valid),
    .second_idx       (g1_idx),
    .new_grant_second (g1_new),
    .second_sel       (g1_sel)
  );

  assign iss0_valid_o  = g0_valid;
  assign iss1_valid_o  = g1_valid;
  assign iss0_bypass_o = g0_valid & g0_new;
  assign iss1_bypass_o = g1_valid & g1_new;

  always_comb begin
    iss0_data_o = '0;
    iss1_data_o = '0;
    if (g0_valid) iss0_data_o = g0_new ? (g0_sel ? enq1_data_i : enq0_data_i) : ent_q[g0_idx].data;
    if (g1_valid) iss1_data_o = g1_new ? (g1_sel ? enq1_data_i : enq0_data_i) : ent_q[g1_idx].data;
  end

  assign acc0 = enq0_valid_i & enq_ready_o & ~flush_i;
  assign acc1 = enq1_valid_i & enq_ready_o & ~flush_i;
  assign wr0  = acc0 & ~grant_new[0];
  assign wr1  = acc1 & ~grant_new[1];

  always_comb begin
    ent_n   = ent_q;
    wr_ptr  = tail_q;
    valid_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && wake_mask_i[i]) ent_n[i].ready = 1'b1;
      if (grant[i]) begin
        ent_n[i].valid = 1'b0;
        ent_n[i].ready = 1'b0;
      end
    end
    if (wr0) begin
      ent_n[wr_ptr[PTR_W-1:0]].valid = 1'b1;
      ent_n[wr_ptr[PTR_W-1:0]].ready = enq0_rdy_i;
      ent_n[wr_ptr[PTR_W-1:0]].data  = enq0_data_i;
      wr_ptr = wr_ptr + 1'b1;
    end
    if (wr1) begin
      ent_n[wr_ptr[PTR_W-1:0]].valid = 1'b1;
      ent_n[wr_ptr[PTR_W-1:0]].ready = enq1_rdy_i;
      ent_n[wr_ptr[PTR_W-1:0]].data  = enq1_data_i;
      wr_ptr = wr_ptr + 1'b1;
    end
    tail_n = wr_ptr;
    for (int i = 0; i < DEPTH; i++) valid_n[i] = ent_n[i].valid;
    head_n = next_head(valid_n, head_q, tail_n);
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_n[i].valid = 1'b0;
        ent_n[i].ready = 1'b0;
      end
      head_n = '0;
      tail_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_n;
      tail_q <= tail_n;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
    end
  end

endmodule
